level_countdown_timer: RTL and testbench
========================================

# level_countdown_timer

Parametrised per-level countdown timer for the speed-typing game. It replaces the fixed three-difficulty timer. On `start` it loads a time budget of `num_char` × per-difficulty budget and counts down in coarse ticks. It adds time on a correct keystroke, subtracts time on a wrong one, and reports the remaining time, a low-time warning and a one-cycle expiry pulse to the game-control FSM and display path.

## Interface
Parameters:
- `TICK_CYC`, 5_000_000: clock cycles per tick (100 ms at 50 MHz).
- `TICK_W`, 16: width of the tick counter and `time_left`.
- `CHAR_W`, 8: width of `num_char`.
- `BUDGET_EASY`, 20: ticks per character, difficulty 1.
- `BUDGET_MED`, 10: ticks per character, difficulty 2.
- `BUDGET_HARD`, 2: ticks per character, difficulty 0 and 3.
- `BONUS`, 5: ticks added per `bonus` pulse.
- `PENALTY`, 10: ticks removed per `penalty` pulse.
- `WARN_TICKS`, 30: `warn` threshold.

Ports:
- `clk`, in, 1: system clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: load the budget and enter RUN.
- `abort`, in, 1: return to IDLE.
- `num_char`, in, CHAR_W: characters in the level; sampled on `start`.
- `difficulty`, in, 2: budget select; sampled on `start`.
- `enable`, in, 1: count enable; low means paused.
- `bonus`, in, 1: correct-keystroke pulse.
- `penalty`, in, 1: wrong-keystroke pulse.
- `time_left`, out, TICK_W: registered ticks remaining.
- `busy`, out, 1: state is RUN.
- `expired`, out, 1: state is EXPIRED.
- `expire_pulse`, out, 1: one cycle, on entry to EXPIRED.
- `warn`, out, 1: RUN and `time_left` <= WARN_TICKS.
- `tick_pulse`, out, 1: one cycle, each time `time_left` decrements.

## Operation
- **States**
  - IDLE: reset state.
  - RUN: counting.
  - EXPIRED: held until `start`, `abort` or reset.
- **Budget load**
  - Budget = `num_char` × BUDGET_x, computed at full product width.
  - The product saturates to 2^TICK_W−1.
- **Prescaler**
  - Counts TICK_CYC−1 down to 0.
  - Decrements only in RUN with `enable` high.
  - At 0 it reloads TICK_CYC−1 and decrements `time_left` by one (`dec`=1); `tick_pulse` is high that cycle.
  - When `enable` is low, the prescaler and `time_left` hold.
- **Bonus and penalty** (RUN only; ignored in IDLE and EXPIRED; applied regardless of `enable`)
  - `bonus`: new = min(`time_left` − dec + BONUS, 2^TICK_W−1).
  - `penalty`: new = max(`time_left` − dec − PENALTY, 0).
  - If both are high in the same cycle, `penalty` wins and `bonus` is dropped.
- **Priority per cycle:** `abort` > `start` > penalty > bonus > decrement.
  - `abort`: IDLE, `time_left`=0, prescaler=0.
  - `start` from any state: `time_left`=budget, prescaler=TICK_CYC−1, state RUN. A restart during RUN discards the remaining time with no expiry pulse.
- **Expiry**
  - In RUN, if the registered `time_left` is 0, the next edge enters EXPIRED and raises `expire_pulse` for exactly one cycle.
  - This also applies when `start` loads 0 (`num_char`=0).
  - In EXPIRED, `time_left`=0 and `warn`=0.
- **Asynchronous reset:** forces IDLE, clears the prescaler, and drives every output to 0 immediately, mid-run included.

## Timing
- All outputs are registered.
- **After `start` at edge E:**
  - `busy`=1 and `time_left`=budget are visible after E.
  - The first decrement occurs at edge E+TICK_CYC (enable held high).
- **Expiry latency:**
  - With `enable` held high, EXPIRED is entered at edge E + budget×TICK_CYC + 1.
  - Each paused cycle delays expiry by exactly one cycle.
- **Bonus/penalty latency:** `time_left` reflects a bonus/penalty one edge after the pulse.
- **Pulse width:** `expire_pulse` and `tick_pulse` are single-cycle pulses and never held.
- **Back-to-back starts:** `start` in consecutive cycles reloads each cycle, with no expiry.

## Test plan
Bench parameters: TICK_CYC=4, TICK_W=8, BUDGET_EASY=3, BUDGET_MED=2, BUDGET_HARD=1, BONUS=2, PENALTY=3, WARN_TICKS=2.

- **Basic run:** reset, then `start` with `num_char`=2, `difficulty`=1, `enable`=1 → `time_left`=6 after E; `tick_pulse` every 4 cycles; `warn` rises when `time_left`=2; `expire_pulse` high for exactly one cycle at E+25; `expired`=1 thereafter.
- **Pause:** same run with `enable` low for 10 cycles mid-run → `time_left` frozen during the pause; expiry at E+35.
- **Saturation:** `num_char`=255, `difficulty`=1 → `time_left`=255 (not 765 mod 256). A `bonus` at `time_left`=254 with no decrement → 255.
- **Penalty and conflicts:**
  - `penalty` at `time_left`=2 → 0, then EXPIRED on the following edge.
  - `bonus`+`penalty` together at 5 → 2.
  - `bonus`/`penalty` in IDLE and EXPIRED → no change.
- **Difficulty and zero cases:**
  - `difficulty`=0 and 3 with `num_char`=4 → 4; `difficulty`=2 → 8.
  - `num_char`=0 → `expire_pulse` one cycle after the `start` edge.
  - `start` during RUN → reload with no `expire_pulse`.
- **Reset and abort:**
  - Asserting `resetn` low mid-run, between clock edges → all outputs 0 immediately, state IDLE.
  - `abort` together with `start` → IDLE, `busy`=0.

Source files
------------

// File: rtl/level_countdown_timer.sv
// Per-level countdown timer for the speed-typing game.
// Loads num_char x difficulty budget, ticks down, applies bonus/penalty.
module level_countdown_timer #(
  parameter int unsigned TICK_CYC    = 5_000_000,
  parameter int unsigned TICK_W      = 16,
  parameter int unsigned CHAR_W      = 8,
  parameter int unsigned BUDGET_EASY = 20,
  parameter int unsigned BUDGET_MED  = 10,
  parameter int unsigned BUDGET_HARD = 2,
  parameter int unsigned BONUS       = 5,
  parameter int unsigned PENALTY     = 10,
  parameter int unsigned WARN_TICKS  = 30
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAR_W-1:0] num_char,
  input  logic [1:0]        difficulty,
  input  logic              enable,
  input  logic              bonus,
  input  logic              penalty,
  output logic [TICK_W-1:0] time_left,
  output logic              busy,
  output logic              expired,
  output logic              expire_pulse,
  output logic              warn,
  output logic              tick_pulse
);

  localparam int unsigned PS_W =
    (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned WW = TICK_W + CHAR_W + 32;
  localparam logic [PS_W-1:0] PS_LOAD = PS_W'(TICK_CYC - 1);
  localparam logic [WW-1:0] T_MAX = WW'({TICK_W{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_EXP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PS_W-1:0]   r_presc;
  logic [PS_W-1:0]   w_presc_nxt;
  logic [TICK_W-1:0] r_time;
  logic [TICK_W-1:0] w_time_nxt;
  logic              r_exp_pulse;
  logic              r_tick;
  logic              r_warn;
  logic              w_exp_nxt;
  logic              w_warn_nxt;
  logic              w_tick_nxt;
  logic              w_dec;
  logic [31:0]       w_bud;
  logic [WW-1:0]     w_prod;
  logic [WW-1:0]     w_base;
  logic [WW-1:0]     w_bon;
  logic [TICK_W-1:0] w_sub;
  logic [TICK_W-1:0] w_budget;
  logic [TICK_W-1:0] w_pen;
  logic [TICK_W-1:0] w_bon_sat;

  always_comb begin
    unique case (difficulty)
      2'd1:    w_bud = 32'(BUDGET_EASY);
      2'd2:    w_bud = 32'(BUDGET_MED);
      default: w_bud = 32'(BUDGET_HARD);
    endcase
  end

  // Full-width product so large levels clamp instead of wrapping
  assign w_prod   = WW'(num_char) * WW'(w_bud);
  assign w_budget = (w_prod > T_MAX) ? '1
                                     : w_prod[TICK_W-1:0];

  assign w_dec = (r_state == S_RUN) && !abort && !start &&
                 (r_time != '0) && enable &&
                 (r_presc == '0);

  assign w_base    = WW'(r_time) - WW'(w_dec);
  assign w_bon     = w_base + WW'(BONUS);
  assign w_bon_sat = (w_bon > T_MAX) ? '1
                                     : w_bon[TICK_W-1:0];
  assign w_sub     = TICK_W'(w_base - WW'(PENALTY));
  assign w_pen     = (w_base > WW'(PENALTY)) ? w_sub : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort)
      w_state_nxt = S_IDLE;
    else if (start)
      w_state_nxt = S_RUN;
    else if (r_state == S_RUN && r_time == '0)
      w_state_nxt = S_EXP;
  end

  always_comb begin
    w_time_nxt  = r_time;
    w_presc_nxt = r_presc;
    if (abort) begin
      w_time_nxt  = '0;
      w_presc_nxt = '0;
    end else if (start) begin
      w_time_nxt  = w_budget;
      w_presc_nxt = PS_LOAD;
    end else if (r_state == S_RUN) begin
      if (r_time == '0) begin
        w_presc_nxt = '0;
      end else begin
        if (enable)
          w_presc_nxt = w_dec ? PS_LOAD
                              : r_presc - PS_W'(1);
        if (penalty)
          w_time_nxt = w_pen;
        else if (bonus)
          w_time_nxt = w_bon_sat;
        else
          w_time_nxt = w_base[TICK_W-1:0];
      end
    end
  end

  always_comb begin
    w_exp_nxt  = (r_state == S_RUN) &&
                 (w_state_nxt == S_EXP);
    w_warn_nxt = (w_state_nxt == S_RUN) &&
                 (WW'(w_time_nxt) <= WW'(WARN_TICKS));
    w_tick_nxt = w_dec;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc     <= '0;
      r_time      <= '0;
      r_exp_pulse <= 1'b0;
      r_tick      <= 1'b0;
      r_warn      <= 1'b0;
    end else begin
      r_presc     <= w_presc_nxt;
      r_time      <= w_time_nxt;
      r_exp_pulse <= w_exp_nxt;
      r_tick      <= w_tick_nxt;
      r_warn      <= w_warn_nxt;
    end
  end

  assign time_left    = r_time;
  assign busy         = (r_state == S_RUN);
  assign expired      = (r_state == S_EXP);
  assign expire_pulse = r_exp_pulse;
  assign warn         = r_warn;
  assign tick_pulse   = r_tick;

endmodule

// File: tb/tb_level_countdown_timer.sv
// Bench for level_countdown_timer: cycle scoreboard
// plus per-scenario directed checks.
module tb_level_countdown_timer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] num_char = '0;
  logic [1:0] difficulty = '0;
  logic       enable = 1'b0;
  logic       bonus = 1'b0;
  logic       penalty = 1'b0;
  logic [7:0] time_left;
  logic       busy;
  logic       expired;
  logic       expire_pulse;
  logic       warn;
  logic       tick_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [7:0] tl;
    logic       busy;
    logic       expired;
    logic       ep;
    logic       warn;
    logic       tp;
  } exp_t;

  exp_t sb_q[$];
  int   m_st = 0;
  int   m_t = 0;
  int   m_p = 0;

  level_countdown_timer #(
    .TICK_CYC(4), .TICK_W(8), .CHAR_W(8),
    .BUDGET_EASY(3), .BUDGET_MED(2),
    .BUDGET_HARD(1), .BONUS(2), .PENALTY(3),
    .WARN_TICKS(2)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .abort(abort), .num_char(num_char),
    .difficulty(difficulty), .enable(enable),
    .bonus(bonus), .penalty(penalty),
    .time_left(time_left), .busy(busy),
    .expired(expired), .expire_pulse(expire_pulse),
    .warn(warn), .tick_pulse(tick_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: 0=IDLE 1=RUN 2=EXPIRED
  always begin : monitor
    exp_t e;
    exp_t a;
    int   dec;
    int   bud;
    int   base;
    @(posedge clk);
    dec = 0;
    e = '0;
    if (!resetn) begin
      m_st = 0; m_t = 0; m_p = 0;
    end else if (abort) begin
      m_st = 0; m_t = 0; m_p = 0;
    end else if (start) begin
      bud = (difficulty == 2'd1) ? 3 :
            (difficulty == 2'd2) ? 2 : 1;
      m_t = int'(num_char) * bud;
      if (m_t > 255) m_t = 255;
      m_p = 3;
      m_st = 1;
    end else if (m_st == 1) begin
      if (m_t == 0) begin
        m_st = 2;
        e.ep = 1'b1;
        m_p = 0;
      end else begin
        if (enable) begin
          if (m_p == 0) begin
            m_p = 3;
            dec = 1;
          end else begin
            m_p = m_p - 1;
          end
        end
        base = m_t - dec;
        if (penalty)
          m_t = (base > 3) ? base - 3 : 0;
        else if (bonus)
          m_t = (base + 2 > 255) ? 255 : base + 2;
        else
          m_t = base;
      end
    end
    e.tl      = 8'(m_t);
    e.busy    = (m_st == 1);
    e.expired = (m_st == 2);
    e.warn    = (m_st == 1) && (m_t <= 2);
    e.tp      = (dec == 1);
    sb_q.push_back(e);
    #1;
    a = {time_left, busy, expired,
         expire_pulse, warn, tick_pulse};
    e = sb_q.pop_front();
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      $display("FAIL scoreboard @%0t: got tl=%0d b=%b x=%b ep=%b w=%b tp=%b want tl=%0d b=%b x=%b ep=%b w=%b tp=%b",
        $time, a.tl, a.busy, a.expired, a.ep,
        a.warn, a.tp, e.tl, e.busy, e.expired,
        e.ep, e.warn, e.tp);
    end
  end

  task automatic do_start(input int n, input int d);
    @(negedge clk);
    num_char = 8'(n);
    difficulty = 2'(d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({time_left, busy, expired, expire_pulse,
         warn, tick_pulse} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got tl=%0d busy=%b, want all 0",
        time_left, busy);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int ep_k = -1;
    int ep_n = 0;
    int ticks = 0;
    int warn_k = -1;
    enable = 1'b1;
    do_start(2, 1);
    tests_run++;
    if (time_left !== 8'd6 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_load: got %0d/%b, want 6/1",
        time_left, busy);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (expire_pulse === 1'b1) begin
        ep_n++;
        if (ep_k < 0) ep_k = k;
      end
      if (tick_pulse === 1'b1) ticks++;
      if (warn === 1'b1 && warn_k < 0) warn_k = k;
    end
    tests_run++;
    if (ep_k != 25 || ep_n != 1) begin
      tests_failed++;
      $display("FAIL basic_expiry: got k=%0d n=%0d, want k=25 n=1",
        ep_k, ep_n);
    end
    tests_run++;
    if (ticks != 6 || warn_k != 16) begin
      tests_failed++;
      $display("FAIL basic_ticks: got ticks=%0d warn_k=%0d, want 6/16",
        ticks, warn_k);
    end
    tests_run++;
    if (expired !== 1'b1 || time_left !== 8'd0) begin
      tests_failed++;
      $display("FAIL basic_hold: got x=%b tl=%0d, want 1/0",
        expired, time_left);
    end
  endtask

  task automatic test_pause();
    int ep_k = -1;
    int bad = 0;
    enable = 1'b1;
    do_start(2, 1);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (expire_pulse === 1'b1 && ep_k < 0) ep_k = k;
      if (k >= 5 && k <= 15 &&
          (time_left !== 8'd5 ||
           (k > 5 && tick_pulse !== 1'b0)))
        bad++;
      if (k == 5) enable = 1'b0;
      if (k == 15) enable = 1'b1;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL pause_freeze: got %0d bad cycles, want 0", bad);
    end
    tests_run++;
    if (ep_k != 35) begin
      tests_failed++;
      $display("FAIL pause_expiry: got k=%0d, want 35", ep_k);
    end
  endtask

  task automatic test_saturation();
    enable = 1'b1;
    do_start(255, 1);
    tests_run++;
    if (time_left !== 8'd255) begin
      tests_failed++;
      $display("FAIL sat_load: got %0d, want 255", time_left);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (time_left !== 8'd254) begin
      tests_failed++;
      $display("FAIL sat_tick: got %0d, want 254", time_left);
    end
    bonus = 1'b1;
    @(negedge clk);
    bonus = 1'b0;
    tests_run++;
    if (time_left !== 8'd255) begin
      tests_failed++;
      $display("FAIL sat_bonus: got %0d, want 255", time_left);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_penalty();
    enable = 1'b1;
    do_start(2, 3);
    penalty = 1'b1;
    @(negedge clk);
    penalty = 1'b0;
    tests_run++;
    if (time_left !== 8'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL pen_floor: got %0d/%b, want 0/1",
        time_left, busy);
    end
    @(negedge clk);
    tests_run++;
    if (expired !== 1'b1 || expire_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL pen_expire: got x=%b ep=%b, want 1/1",
        expired, expire_pulse);
    end
    bonus = 1'b1;
    @(negedge clk);
    bonus = 1'b0;
    penalty = 1'b1;
    @(negedge clk);
    penalty = 1'b0;
    tests_run++;
    if (time_left !== 8'd0 || expired !== 1'b1 ||
        expire_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL pen_in_expired: got tl=%0d x=%b ep=%b, want 0/1/0",
        time_left, expired, expire_pulse);
    end
    do_start(5, 0);
    bonus = 1'b1;
    penalty = 1'b1;
    @(negedge clk);
    bonus = 1'b0;
    penalty = 1'b0;
    tests_run++;
    if (time_left !== 8'd2) begin
      tests_failed++;
      $display("FAIL pen_conflict: got %0d, want 2", time_left);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bonus = 1'b1;
    @(negedge clk);
    bonus = 1'b0;
    penalty = 1'b1;
    @(negedge clk);
    penalty = 1'b0;
    tests_run++;
    if (time_left !== 8'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL pen_in_idle: got %0d/%b, want 0/0",
        time_left, busy);
    end
  endtask

  task automatic test_difficulty();
    int want[3] = '{4, 4, 8};
    int diff[3] = '{0, 3, 2};
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_start(4, diff[i]);
      tests_run++;
      if (time_left !== 8'(want[i]) ||
          expire_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL diff_%0d: got %0d ep=%b, want %0d ep=0",
          diff[i], time_left, expire_pulse, want[i]);
      end
    end
  endtask

  task automatic test_zero();
    do_start(0, 1);
    tests_run++;
    if (busy !== 1'b1 || time_left !== 8'd0 ||
        expire_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_load: got b=%b tl=%0d ep=%b, want 1/0/0",
        busy, time_left, expire_pulse);
    end
    @(negedge clk);
    tests_run++;
    if (expire_pulse !== 1'b1 || expired !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_expire: got ep=%b x=%b, want 1/1",
        expire_pulse, expired);
    end
    @(negedge clk);
    tests_run++;
    if (expire_pulse !== 1'b0 || expired !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_pulse_width: got ep=%b x=%b, want 0/1",
        expire_pulse, expired);
    end
  endtask

  task automatic test_restart();
    enable = 1'b1;
    do_start(1, 3);
    repeat (4) @(negedge clk);
    tests_run++;
    if (time_left !== 8'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_pre: got %0d/%b, want 0/1",
        time_left, busy);
    end
    num_char = 8'd3;
    difficulty = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (expire_pulse !== 1'b0 || time_left !== 8'd3 ||
        busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_reload: got ep=%b tl=%0d b=%b, want 0/3/1",
        expire_pulse, time_left, busy);
    end
  endtask

  task automatic test_back_to_back();
    enable = 1'b1;
    @(negedge clk);
    difficulty = 2'd1;
    start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      num_char = 8'(i);
      @(negedge clk);
      tests_run++;
      if (time_left !== 8'(3 * i) ||
          expire_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_%0d: got %0d ep=%b, want %0d ep=0",
          i, time_left, expire_pulse, 3 * i);
      end
    end
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (time_left !== 8'd9 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_hold: got %0d/%b, want 9/1",
        time_left, busy);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    do_start(10, 1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if ({time_left, busy, expired, expire_pulse,
         warn, tick_pulse} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got tl=%0d busy=%b, want all 0",
        time_left, busy);
    end
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_abort_start();
    do_start(3, 1);
    num_char = 8'd5;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || time_left !== 8'd0 ||
        expire_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_start: got b=%b tl=%0d ep=%b, want 0/0/0",
        busy, time_left, expire_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_saturation();
    test_penalty();
    test_difficulty();
    test_zero();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_abort_start();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed",
      tests_run, tests_failed);
    $finish;
  end

endmodule
